// File: rtl/controle_bateria_if.sv
// Purpose: signal bundle between the power/on-off logic, the battery charge
//          model and the battery LED indicator stage.
// Signals:
//   ligado, motor_ativo, na_base  : status inputs into the battery model
//   nivel[3:0]                    : current charge level
//   control, leds[8:0]            : LED indicator enable and thermometer bar
//   motor_habilita, retornar_base,
//   bateria_vazia                 : flags to the motion logic
// Modports: master = environment driving the status inputs,
//           slave  = battery model (controle_bateria).
interface controle_bateria_if;
  logic       ligado;
  logic       motor_ativo;
  logic       na_base;
  logic [3:0] nivel;
  logic       control;
  logic [8:0] leds;
  logic       motor_habilita;
  logic       retornar_base;
  logic       bateria_vazia;

  modport master (
    output ligado, motor_ativo, na_base,
    input  nivel, control, leds, motor_habilita, retornar_base, bateria_vazia
  );

  modport slave (
    input  ligado, motor_ativo, na_base,
    output nivel, control, leds, motor_habilita, retornar_base, bateria_vazia
  );
endinterface

// File: rtl/controle_bateria.sv
// Purpose: battery charge model for the vacuum robot. Keeps a 0..NIVEL_MAX
//          charge level that drains while the motors run and refills while
//          docked, and decodes LED bar and low/empty flags from it.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous reset, active-low
//   bus      : controle_bateria_if.slave (status inputs, level, LEDs, flags)
module controle_bateria #(
  parameter int NIVEL_MAX      = 9,
  parameter int NIVEL_BAIXO    = 3,
  parameter int TICKS_DESCARGA = 50_000_000,
  parameter int TICKS_CARGA    = 25_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  controle_bateria_if.slave   bus
);

  localparam logic [2:0] DESLIGADO  = 3'd0;
  localparam logic [2:0] OPERANDO   = 3'd1;
  localparam logic [2:0] BAIXA      = 3'd2;
  localparam logic [2:0] VAZIA      = 3'd3;
  localparam logic [2:0] CARREGANDO = 3'd4;

  localparam int TICKS_MAX = (TICKS_DESCARGA > TICKS_CARGA) ? TICKS_DESCARGA : TICKS_CARGA;
  localparam int CNT_W     = (TICKS_MAX > 1) ? $clog2(TICKS_MAX) : 1;

  localparam logic [CNT_W-1:0] DESC_FIM    = CNT_W'(TICKS_DESCARGA - 1);
  localparam logic [CNT_W-1:0] CARGA_FIM   = CNT_W'(TICKS_CARGA - 1);
  localparam logic [CNT_W-1:0] CNT_UM      = CNT_W'(1);
  localparam logic [3:0]       NIVEL_MAX_V = 4'(NIVEL_MAX);
  localparam logic [3:0]       NIVEL_BX_V  = 4'(NIVEL_BAIXO);

  logic [2:0]       state_r;
  logic [2:0]       state_next_s;
  logic [3:0]       nivel_r;
  logic [3:0]       nivel_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_calc_s;
  logic [CNT_W-1:0] cnt_next_s;

  logic             control_r;
  logic [8:0]       leds_r;
  logic             motor_habilita_r;
  logic             retornar_base_r;
  logic             bateria_vazia_r;

  // Thermometer bar: LED i lit when enabled and the level is above i.
  function automatic logic [8:0] barra(input logic ctl, input logic [3:0] niv);
    logic [8:0] b;
    b = 9'h000;
    for (int i = 0; i < 9; i++) begin
      b[i] = ctl & (niv > 4'(i));
    end
    return b;
  endfunction

  // Prescaler and level update for the current state.
  always_comb begin
    cnt_calc_s   = cnt_r;
    nivel_next_s = nivel_r;
    case (state_r)
      OPERANDO, BAIXA: begin
        if (bus.motor_ativo) begin
          if (cnt_r == DESC_FIM) begin
            cnt_calc_s = '0;
            if (nivel_r != 4'd0) begin
              nivel_next_s = nivel_r - 4'd1;
            end else begin
              nivel_next_s = nivel_r;
            end
          end else begin
            cnt_calc_s = cnt_r + CNT_UM;
          end
        end else begin
          cnt_calc_s = cnt_r;
        end
      end
      CARREGANDO: begin
        // Once full the prescaler idles at 0 so a later discharge starts clean.
        if (nivel_r >= NIVEL_MAX_V) begin
          cnt_calc_s = '0;
        end else if (cnt_r == CARGA_FIM) begin
          cnt_calc_s   = '0;
          nivel_next_s = nivel_r + 4'd1;
        end else begin
          cnt_calc_s = cnt_r + CNT_UM;
        end
      end
      default: begin
        cnt_calc_s = '0;
      end
    endcase
  end

  // Next state uses the level written on this same edge, so threshold
  // crossings change state without an extra cycle of delay.
  always_comb begin
    state_next_s = OPERANDO;
    if (bus.na_base) begin
      state_next_s = CARREGANDO;
    end else if (!bus.ligado) begin
      state_next_s = DESLIGADO;
    end else if (nivel_next_s == 4'd0) begin
      state_next_s = VAZIA;
    end else if (nivel_next_s <= NIVEL_BX_V) begin
      state_next_s = BAIXA;
    end else begin
      state_next_s = OPERANDO;
    end
    if (state_next_s != state_r) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_calc_s;
    end
  end

  // State, level, prescaler and output registers; outputs are decoded from
  // the next-state values so they match the state registers with no lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= DESLIGADO;
      nivel_r          <= NIVEL_MAX_V;
      cnt_r            <= '0;
      control_r        <= 1'b0;
      leds_r           <= 9'h000;
      motor_habilita_r <= 1'b0;
      retornar_base_r  <= 1'b0;
      bateria_vazia_r  <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      nivel_r          <= nivel_next_s;
      cnt_r            <= cnt_next_s;
      control_r        <= (state_next_s != DESLIGADO);
      leds_r           <= barra(state_next_s != DESLIGADO, nivel_next_s);
      motor_habilita_r <= (state_next_s == OPERANDO) || (state_next_s == BAIXA);
      retornar_base_r  <= (state_next_s == BAIXA);
      bateria_vazia_r  <= (state_next_s == VAZIA);
    end
  end

  assign bus.nivel          = nivel_r;
  assign bus.control        = control_r;
  assign bus.leds           = leds_r;
  assign bus.motor_habilita = motor_habilita_r;
  assign bus.retornar_base  = retornar_base_r;
  assign bus.bateria_vazia  = bateria_vazia_r;

endmodule
